serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx_if.sv | 12 +
 rtl/serial_frame_tx.sv | 112 +++++++++++
 tb/tb_serial_frame_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Word-level handshake between a producer and the serial frame transmitter.
// The producer offers tx_data with tx_valid; the transmitter answers with tx_ready.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Serializes one parallel word per frame: start bit, data LSB first, optional even
// parity, stop bit. Each bit is held for CLKS_PER_BIT clocks.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_tx_if.slave   tx,
    output logic               tx_line,
    output logic               tx_line_n,
    output logic               tx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]      CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              parity_reg, parity_next;
    logic              line_reg, line_next;
    logic              line_n_reg;
    logic              busy_reg;
    logic              bit_end;

    assign tx.tx_ready = (state_reg == IDLE) && !reset;
    assign tx_line     = line_reg;
    assign tx_line_n   = line_n_reg;
    assign tx_busy     = busy_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            line_reg   <= 1'b1;
            line_n_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            line_reg   <= line_next;
            line_n_reg <= ~line_next;
            busy_reg   <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        line_next   = 1'b1;
        bit_end     = (cnt_reg == CNT_LAST);

        if (state_reg != IDLE)
            cnt_next = bit_end ? 8'd0 : cnt_reg + 8'd1;

        case (state_reg)
            IDLE: begin
                if (tx.tx_valid) begin
                    state_next  = START;
                    shift_next  = tx.tx_data;
                    parity_next = ^tx.tx_data;
                    cnt_next    = '0;
                    idx_next    = '0;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    // The register shifts so the next data bit always sits at bit 0.
                    shift_next = shift_reg >> 1;
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // The line level is decoded from the upcoming state so the output stays registered.
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
            PARITY:  line_next = parity_next;
            default: line_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: a per-cycle line/busy scoreboard is filled on
// acceptance and drained one entry per clock.
module tb_serial_frame_tx;
    logic clk = 1'b0;
    logic reset;
    logic line_a, line_n_a, busy_a;
    logic line_b, line_n_b, busy_b;

    serial_frame_tx_if #(.DATA_W(8)) if_a ();
    serial_frame_tx_if #(.DATA_W(8)) if_b ();

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .reset(reset), .tx(if_a.slave),
        .tx_line(line_a), .tx_line_n(line_n_a), .tx_busy(busy_a));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clk(clk), .reset(reset), .tx(if_b.slave),
        .tx_line(line_b), .tx_line_n(line_n_b), .tx_busy(busy_b));

    always #5 clk = ~clk;

    logic [1:0] exp_q[$];  // {busy, line} expected per cycle
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0h expected=%0h", name, tag, obs, exp);
        end
    endtask

    task automatic sample(input bit sel, output logic ln, output logic lnn, output logic bz, output logic rdy);
        if (sel) begin ln = line_b; lnn = line_n_b; bz = busy_b; rdy = if_b.tx_ready; end
        else     begin ln = line_a; lnn = line_n_a; bz = busy_a; rdy = if_a.tx_ready; end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin if_b.tx_valid = v; if_b.tx_data = d; end
        else     begin if_a.tx_valid = v; if_a.tx_data = d; end
    endtask

    task automatic push_frame(input logic [7:0] d, input int cpb, input bit par);
        for (int c = 0; c < cpb; c++) exp_q.push_back(2'b10);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < cpb; c++) exp_q.push_back({1'b1, d[b]});
        if (par)
            for (int c = 0; c < cpb; c++) exp_q.push_back({1'b1, ^d});
        for (int c = 0; c < cpb; c++) exp_q.push_back(2'b11);
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
    task automatic run_frame(input bit sel, input logic [7:0] d, input bit hold, input bit toggle, input string name);
        logic ln, lnn, bz, rdy;
        logic [1:0] e;
        int cpb;
        bit par;
        cpb = sel ? 1 : 4;
        par = !sel;
        sample(sel, ln, lnn, bz, rdy);
        check(name, "ready_pre", {7'd0, rdy}, 8'd1);
        drive(sel, 1'b1, d);
        @(posedge clk);
        push_frame(d, cpb, par);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (toggle)     drive(sel, 1'b0, (i % 2 == 0) ? 8'hFF : 8'h00);
            else if (!hold) drive(sel, 1'b0, d);
            e = exp_q.pop_front();
            sample(sel, ln, lnn, bz, rdy);
            check(name, $sformatf("line[%0d]", i), {7'd0, ln}, {7'd0, e[0]});
            check(name, $sformatf("line_n[%0d]", i), {7'd0, lnn}, {7'd0, ~e[0]});
            check(name, $sformatf("busy[%0d]", i), {7'd0, bz}, {7'd0, e[1]});
            check(name, $sformatf("ready[%0d]", i), {7'd0, rdy}, 8'd0);
        end
        @(negedge clk);
        sample(sel, ln, lnn, bz, rdy);
        check(name, "idle_line", {7'd0, ln}, 8'd1);
        check(name, "idle_busy", {7'd0, bz}, 8'd0);
        check(name, "idle_ready", {7'd0, rdy}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic ln, lnn, bz, rdy;
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        #1;
        sample(1'b0, ln, lnn, bz, rdy);
        check("reset_a", "line", {7'd0, ln}, 8'd1);
        check("reset_a", "line_n", {7'd0, lnn}, 8'd0);
        check("reset_a", "busy", {7'd0, bz}, 8'd0);
        check("reset_a", "ready", {7'd0, rdy}, 8'd0);
        sample(1'b1, ln, lnn, bz, rdy);
        check("reset_b", "line", {7'd0, ln}, 8'd1);
        check("reset_b", "ready", {7'd0, rdy}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_frame(1'b0, 8'hA5, 1'b0, 1'b0, "a5");
        run_frame(1'b0, 8'h07, 1'b0, 1'b0, "p07");
        run_frame(1'b0, 8'h00, 1'b0, 1'b0, "z00");
        run_frame(1'b0, 8'h3C, 1'b1, 1'b0, "b2b_3c");
        run_frame(1'b0, 8'hC3, 1'b0, 1'b0, "b2b_c3");
        run_frame(1'b0, 8'h5A, 1'b0, 1'b1, "hold5a");

        // Abort mid-frame during data bit 3 (0x96 has bit 3 = 0, so the line visibly rises).
        drive(1'b0, 1'b1, 8'h96);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h96);
        repeat (17) @(negedge clk);
        sample(1'b0, ln, lnn, bz, rdy);
        check("abort", "pre_line", {7'd0, ln}, 8'd0);
        check("abort", "pre_busy", {7'd0, bz}, 8'd1);
        #1 reset = 1'b1;
        #1;
        sample(1'b0, ln, lnn, bz, rdy);
        check("abort", "line", {7'd0, ln}, 8'd1);
        check("abort", "line_n", {7'd0, lnn}, 8'd0);
        check("abort", "busy", {7'd0, bz}, 8'd0);
        check("abort", "ready", {7'd0, rdy}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        sample(1'b0, ln, lnn, bz, rdy);
        check("release", "ready", {7'd0, rdy}, 8'd1);
        check("release", "line", {7'd0, ln}, 8'd1);
        @(negedge clk);
        run_frame(1'b0, 8'h81, 1'b0, 1'b0, "post81");

        run_frame(1'b1, 8'hFF, 1'b0, 1'b0, "fast_ff");
        run_frame(1'b1, 8'h2D, 1'b0, 1'b0, "fast_2d");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
